// File: rtl/shift_arb_pkg.sv
// Shared types for the shift arbiter: requester ids and output-stage states.
// Imported by the arbiter, the round-robin grant block and the testbench.
package shift_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t ID_REQ0 = 1'b0;
    localparam req_id_t ID_REQ1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // The requester that loses a grant is the one favoured next time.
    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Owns the priority pointer, which moves only
// when a granted request is actually accepted.
module rr_arb2
    import shift_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    valid0,
    input  logic    valid1,
    input  logic    accept,
    output logic    grant0,
    output logic    grant1,
    output req_id_t grant_id,
    output logic    fire
);

    req_id_t ptr;

    always_comb begin
        grant0   = valid0 & (~valid1 | (ptr == ID_REQ0));
        grant1   = valid1 & (~valid0 | (ptr == ID_REQ1));
        grant_id = grant1 ? ID_REQ1 : ID_REQ0;
        fire     = (grant0 | grant1) & accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_REQ0;
        end else if (fire) begin
            ptr <= other_id(grant_id);
        end
    end

endmodule

// File: rtl/sll.sv
// Combinational N-bit logical left shift with zero fill.
// Every bit of the shift amount is honoured: any amount >= N yields zero.
module sll #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    localparam logic [N-1:0] LIMIT = N[N-1:0];

    always_comb begin
        y = '0;
        if (b < LIMIT) begin
            y = a << b;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one sll shifter between two requesters with round-robin arbitration
// and a single-entry registered output stage (full throughput, 1-cycle latency).
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_id,
    input  logic         out_ready
);

    // Handshake: a transfer happens on any edge where valid & ready are both 1.
    // Readies depend combinationally on valids, the pointer, state and out_ready;
    // producers hold valid/payload until ready, and valid never waits on ready.

    out_state_t   state;
    out_state_t   state_next;
    logic         can_accept;
    logic         grant0;
    logic         grant1;
    req_id_t      grant_id;
    logic         fire;
    logic [N-1:0] sh_a;
    logic [N-1:0] sh_b;
    logic [N-1:0] sh_y;

    // Gating with rst_n keeps both readies low for the whole reset window.
    assign can_accept = rst_n & ((state == EMPTY) | out_ready);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .accept   (can_accept),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant_id (grant_id),
        .fire     (fire)
    );

    assign req0_ready = grant0 & can_accept;
    assign req1_ready = grant1 & can_accept;

    assign sh_a = (grant_id == ID_REQ1) ? req1_a : req0_a;
    assign sh_b = (grant_id == ID_REQ1) ? req1_b : req0_b;

    sll #(.N(N)) u_sll (
        .a (sh_a),
        .b (sh_b),
        .y (sh_y)
    );

    always_comb begin
        state_next = state;
        if (fire) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= ID_REQ0;
        end else begin
            state <= state_next;
            if (fire) begin
                out_data <= sh_y;
                out_id   <= grant_id;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter: a driver issues per-cycle vectors with
// hand-derived readies, and a monitor scores each consumed result against exp_q.
module tb_shift_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_ready;

    logic [8:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    shift_arbiter #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        req0_valid = 1'b0;
        req0_a     = 8'h00;
        req0_b     = 8'h00;
        req1_valid = 1'b0;
        req1_a     = 8'h00;
        req1_b     = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        set_idle();
        rst_n = 1'b1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference shift built bit by bit, independent of the operator form.
    function automatic logic [7:0] model_sll(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < int'(b); i++) begin
            r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive just after the edge, check readies mid-cycle, and push
    // the expected result of any request the vector says will be accepted.
    task automatic cyc(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                       input logic ordy, input logic er0, input logic er1,
                       input string tag);
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        out_ready  = ordy;
        @(negedge clk);
        chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(er0));
        chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(er1));
        if (er0) exp_q.push_back({1'b0, model_sll(a0, b0)});
        if (er1) exp_q.push_back({1'b1, model_sll(a1, b1)});
    endtask

    task automatic idle(input logic ordy, input string tag);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, ordy, 1'b0, 1'b0, tag);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got id=%0d data=%02h expected none", out_id, out_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if ({out_id, out_data} !== e) begin
                    n_errors++;
                    $display("FAIL out_result: got id=%0d data=%02h expected id=%0d data=%02h",
                             out_id, out_data, e[8], e[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_idle();
        req0_valid = 1'b1;
        req0_a     = 8'h03;
        req0_b     = 8'h02;

        // 1. reset values, then a single request
        repeat (3) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'h00);
        chk("rst.out_id", 32'(out_id), 32'd0);
        chk("rst.req0_ready", 32'(req0_ready), 32'd0);
        @(posedge clk);
        #1;
        set_idle();
        rst_n = 1'b1;
        cyc(1'b1, 8'h03, 8'd2, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "t1.req");
        idle(1'b0, "t1.hold");
        chk("t1.out_valid", 32'(out_valid), 32'd1);
        chk("t1.out_data", 32'(out_data), 32'h0C);
        chk("t1.out_id", 32'(out_id), 32'd0);
        idle(1'b1, "t1.drain");

        // 2. contention: alternating grants at full rate
        do_reset();
        cyc(1'b1, 8'h01, 8'd1, 1'b1, 8'h01, 8'd3, 1'b1, 1'b1, 1'b0, "t2.c0");
        cyc(1'b1, 8'h01, 8'd1, 1'b1, 8'h01, 8'd3, 1'b1, 1'b0, 1'b1, "t2.c1");
        cyc(1'b1, 8'h01, 8'd1, 1'b1, 8'h01, 8'd3, 1'b1, 1'b1, 1'b0, "t2.c2");
        cyc(1'b1, 8'h01, 8'd1, 1'b1, 8'h01, 8'd3, 1'b1, 1'b0, 1'b1, "t2.c3");
        idle(1'b1, "t2.drain");

        // 3. backpressure: held result, then req0 wins on release
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h81, 8'd1, 1'b0, 1'b0, 1'b1, "t3.load");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h11, 8'd4, 1'b1, 8'h22, 8'd1, 1'b0, 1'b0, 1'b0, "t3.stall");
            chk("t3.out_valid", 32'(out_valid), 32'd1);
            chk("t3.out_data", 32'(out_data), 32'h02);
            chk("t3.out_id", 32'(out_id), 32'd1);
        end
        cyc(1'b1, 8'h11, 8'd4, 1'b1, 8'h22, 8'd1, 1'b1, 1'b1, 1'b0, "t3.release");
        idle(1'b1, "t3.drain");

        // 4. shift boundaries, pipelined at full rate
        cyc(1'b1, 8'hFF, 8'd7, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "t4.b7");
        cyc(1'b1, 8'hFF, 8'd8, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "t4.b8");
        cyc(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "t4.bff");
        cyc(1'b1, 8'hA5, 8'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "t4.b0");
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h3C, 8'h09, 1'b1, 1'b0, 1'b1, "t4.b9");
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h3C, 8'h10, 1'b1, 1'b0, 1'b1, "t4.b16");
        cyc(1'b1, 8'h01, 8'd6, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "t4.b6");
        idle(1'b1, "t4.drain");

        // 5. asynchronous reset while a result is held
        cyc(1'b1, 8'h05, 8'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "t5.load");
        idle(1'b0, "t5.hold");
        chk("t5.out_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5.out_valid_async", 32'(out_valid), 32'd0);
        chk("t5.out_data_async", 32'(out_data), 32'h00);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 8'h07, 8'd2, 1'b1, 8'h09, 8'd3, 1'b1, 1'b1, 1'b0, "t5.first");
        idle(1'b1, "t5.drain");

        // 6. pointer holds across idle cycles
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h0F, 8'd4, 1'b1, 1'b0, 1'b1, "t6.req1");
        for (int i = 0; i < 5; i++) begin
            idle(1'b1, "t6.idle");
        end
        cyc(1'b1, 8'h33, 8'd1, 1'b1, 8'h44, 8'd2, 1'b1, 1'b1, 1'b0, "t6.both");
        idle(1'b1, "t6.drain");
        idle(1'b1, "t6.drain2");

        chk("end.exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
